// File: rtl/dl_shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter (dl_shift_pipe).
// Optional rotate support is selected by the DL_SHIFT_PIPE_ROTATE_EN macro.
package dl_shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    // Shift-amount bits handled by each stage: ceil(num_shift_bits / num_stages).
    function automatic int shift_bits_per_stage(input int num_shift_bits, input int num_stages);
        return (num_shift_bits + num_stages - 1) / num_stages;
    endfunction

    function automatic int stage_lo(input int k, input int bits_per_stage);
        return k * bits_per_stage;
    endfunction

    function automatic int stage_hi(input int k, input int bits_per_stage, input int num_shift_bits);
        int hi;
        hi = (k + 1) * bits_per_stage;
        if (hi > num_shift_bits) begin
            hi = num_shift_bits;
        end
        return hi - 1;
    endfunction

    // Bit mask of shift-amount positions lo..hi; an empty range yields zero.
    function automatic logic [7:0] stage_mask(input int lo, input int hi);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

endpackage

// File: rtl/dl_shift_stage.sv
// One pipeline stage: applies its slice of the shift amount and registers the partial result.
// ROR rotates only when DL_SHIFT_PIPE_ROTATE_EN is defined; otherwise it behaves as SRL.
module dl_shift_stage
    import dl_shift_pkg::*;
#(
    parameter int NUM_BITS       = 32,
    parameter int NUM_SHIFT_BITS = 5,
    parameter int SHIFT_LO       = 0,
    parameter int SHIFT_HI       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      advance,
    input  logic                      in_valid,
    input  logic [NUM_BITS-1:0]       in_data,
    input  logic [NUM_SHIFT_BITS-1:0] in_shift,
    input  shift_op_t                 in_op,
    input  logic                      in_sign,
    output logic                      out_valid,
    output logic [NUM_BITS-1:0]       out_data,
    output logic [NUM_SHIFT_BITS-1:0] out_shift,
    output shift_op_t                 out_op,
    output logic                      out_sign
);

    localparam logic [NUM_SHIFT_BITS-1:0] STAGE_MASK =
        NUM_SHIFT_BITS'(stage_mask(SHIFT_LO, SHIFT_HI));
    localparam logic [NUM_BITS-1:0] ONES = '1;

    logic [NUM_SHIFT_BITS-1:0] amt;
    logic [NUM_BITS-1:0]       fill;
    logic [NUM_BITS-1:0]       shifted;

    assign amt = in_shift & STAGE_MASK;

    always_comb begin
        shifted = in_data;
        // SRA fill comes from the sign captured at acceptance, not the partial data.
        fill    = in_sign ? ~(ONES >> amt) : '0;
        case (in_op)
            OP_SLL:  shifted = in_data << amt;
            OP_SRL:  shifted = in_data >> amt;
            OP_SRA:  shifted = (in_data >> amt) | fill;
`ifdef DL_SHIFT_PIPE_ROTATE_EN
            OP_ROR:  shifted = (in_data >> amt) | (in_data << (NUM_BITS - int'(amt)));
`else
            OP_ROR:  shifted = in_data >> amt;
`endif
            default: shifted = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
            out_op    <= OP_SLL;
            out_sign  <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid & ~flush;
            out_data  <= shifted;
            out_shift <= in_shift & ~STAGE_MASK;
            out_op    <= in_op;
            out_sign  <= in_sign;
        end else if (flush) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dl_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshakes and flush.
// Define DL_SHIFT_PIPE_ROTATE_EN to make ROR a true rotate instead of SRL.
module dl_shift_pipe
    import dl_shift_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int NUM_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_BITS-1:0]         in_data,
    input  logic [$clog2(NUM_BITS)-1:0] in_shift,
    input  logic [1:0]                  in_op,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_BITS-1:0]         out_data
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the valid it is paired with.

    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);
    localparam int BITS_PER_STAGE = shift_bits_per_stage(NUM_SHIFT_BITS, NUM_STAGES);
    localparam int LAST           = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0]     valid_s;
    logic [NUM_STAGES-1:0]     advance;
    logic [NUM_BITS-1:0]       data_s  [NUM_STAGES];
    logic [NUM_SHIFT_BITS-1:0] shift_s [NUM_STAGES];
    shift_op_t                 op_s    [NUM_STAGES];
    logic                      sign_s  [NUM_STAGES];

    // A stage moves when the consumer takes the result or any stage from it to the tail has a hole.
    always_comb begin
        logic full_run;
        advance = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            full_run = 1'b1;
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (j >= k) begin
                    full_run = full_run & valid_s[j];
                end
            end
            advance[k] = out_ready | ~full_run;
        end
    end

    assign in_ready  = advance[0] & ~flush & ~rst;
    assign out_valid = valid_s[LAST];
    assign out_data  = data_s[LAST];

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            localparam int LO = stage_lo(k, BITS_PER_STAGE);
            localparam int HI = stage_hi(k, BITS_PER_STAGE, NUM_SHIFT_BITS);

            logic                      v_in;
            logic [NUM_BITS-1:0]       d_in;
            logic [NUM_SHIFT_BITS-1:0] s_in;
            shift_op_t                 o_in;
            logic                      g_in;

            if (k == 0) begin : g_head
                assign v_in = in_valid & in_ready;
                assign d_in = in_data;
                assign s_in = in_shift;
                assign o_in = shift_op_t'(in_op);
                assign g_in = in_data[NUM_BITS-1];
            end else begin : g_body
                assign v_in = valid_s[k-1];
                assign d_in = data_s[k-1];
                assign s_in = shift_s[k-1];
                assign o_in = op_s[k-1];
                assign g_in = sign_s[k-1];
            end

            dl_shift_stage #(
                .NUM_BITS       (NUM_BITS),
                .NUM_SHIFT_BITS (NUM_SHIFT_BITS),
                .SHIFT_LO       (LO),
                .SHIFT_HI       (HI)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .advance   (advance[k]),
                .in_valid  (v_in),
                .in_data   (d_in),
                .in_shift  (s_in),
                .in_op     (o_in),
                .in_sign   (g_in),
                .out_valid (valid_s[k]),
                .out_data  (data_s[k]),
                .out_shift (shift_s[k]),
                .out_op    (op_s[k]),
                .out_sign  (sign_s[k])
            );
        end
    endgenerate

    // The tail stage's leftover control fields have no consumer.
    logic unused_tail;
    assign unused_tail = ^{shift_s[LAST], op_s[LAST], sign_s[LAST]};

endmodule

// File: tb/tb_dl_shift_pipe.sv
// Self-checking bench for dl_shift_pipe (NUM_BITS=32, NUM_STAGES=2) with a queue-based reference model.
// Expected ROR results follow DL_SHIFT_PIPE_ROTATE_EN.
module tb_dl_shift_pipe;

    localparam int W  = 32;
    localparam int NS = 2;
    localparam int SB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SB-1:0] in_shift;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d;

    dl_shift_pipe #(.NUM_BITS(W), .NUM_STAGES(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference: the whole shift done in one step with plain operators.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic [1:0] op);
        logic signed [W-1:0] sd;
        logic [W-1:0] r;
        sd = d;
        case (op)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = sd >>> s;
`ifdef DL_SHIFT_PIPE_ROTATE_EN
            default: r = (s == 0) ? d : ((d >> s) | (d << (W - s)));
`else
            default: r = d >> s;
`endif
        endcase
        return r;
    endfunction

    // Scoreboard: push on accepted requests, pop and compare on delivered results.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                total++;
                if (!out_valid || out_data !== hold_d) begin
                    bad++;
                    $display("FAIL hold_stable: out_valid=%b out_data=%h required valid=1 data=%h", out_valid, out_data, hold_d);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: out_data=%h with no request pending", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL scoreboard: out_data=%h required %h", out_data, e);
                    end
                end
            end
            hold_v = out_valid && !out_ready && !flush;
            hold_d = out_data;
            if (flush) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_in_flush: in_ready=%b required 0", in_ready);
                end
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_data, int'(in_shift), in_op));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [W-1:0] d, input int s, input logic [1:0] op);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = SB'(s);
        in_op    = op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        total += 3;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: %b required 0", out_valid); end
        if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: %h required 0", out_data); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: %b required 1", in_ready); end
        tick();
    endtask

    // One request on an idle pipe; checks acceptance, latency and the result.
    task automatic directed_one(input string name, input logic [W-1:0] d, input int s,
                                input logic [1:0] op, input logic [W-1:0] expv);
        int lat;
        bit got;
        out_ready = 1'b1;
        set_req(d, s, op);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready); end
        tick();
        in_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            lat = i;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout: no out_valid within 10 cycles, required result %h", name, expv);
        end else begin
            if (lat != NS || out_data !== expv) begin
                bad++;
                $display("FAIL %s: data=%h latency=%0d required data=%h latency=%0d", name, out_data, lat, expv, NS);
            end
            tick();
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ror_exp;
`ifdef DL_SHIFT_PIPE_ROTATE_EN
        ror_exp = 32'h8000_0000;
`else
        ror_exp = 32'h0000_0000;
`endif
        directed_one("sra_31",   32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
        directed_one("srl_31",   32'h8000_0000, 31, 2'b01, 32'h0000_0001);
        directed_one("sll_31",   32'h0000_0001, 31, 2'b00, 32'h8000_0000);
        directed_one("sll_0",    32'h1234_5678, 0,  2'b00, 32'h1234_5678);
        directed_one("srl_0",    32'h1234_5678, 0,  2'b01, 32'h1234_5678);
        directed_one("sra_0",    32'h1234_5678, 0,  2'b10, 32'h1234_5678);
        directed_one("ror_0",    32'h1234_5678, 0,  2'b11, 32'h1234_5678);
        directed_one("ror_1",    32'h0000_0001, 1,  2'b11, ror_exp);
        directed_one("sra_pos",  32'h7000_0000, 4,  2'b10, 32'h0700_0000);
        directed_one("sra_neg",  32'h9000_0000, 9,  2'b10, 32'hFFC8_0000);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got_q[$];
        logic [W-1:0] want [4];
        int sent;
        want[0] = 32'hF000_0000;
        want[1] = 32'h0F00_0000;
        want[2] = 32'h00F0_0000;
        want[3] = 32'h000F_0000;
        sent = 0;
        for (int t = 0; t < 40; t++) begin
            out_ready = (t >= 3);
            if (sent < 4) set_req(32'hF000_0000, sent * 4, 2'b01);
            else in_valid = 1'b0;
            @(negedge clk);
            if (t <= 2) begin
                total++;
                if (in_ready !== (t < 2)) begin
                    bad++;
                    $display("FAIL b2b_in_ready_t%0d: %b required %b", t, in_ready, (t < 2));
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            tick();
            if (got_q.size() == 4) break;
        end
        in_valid = 1'b0;
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d results required 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++;
            if (got_q[i] !== want[i]) begin
                bad++;
                $display("FAIL b2b_result_%0d: %h required %h", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(32'h0000_0003 << i, 2, 2'b00);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_accept_%0d: in_ready=%b required 1", i, in_ready); end
            tick();
        end
        set_req(32'hDEAD_BEEF, 3, 2'b00);
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: out_valid=%b required 1", out_valid); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop: out_valid=%b required 0", out_valid); end
        tick();
        directed_one("after_flush", 32'h0000_0001, 1, 2'b00, 32'h0000_0002);
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(32'h0000_00F0, 1 + i, 2'b01);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: in_ready=%b required 0", in_ready); end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: in_ready=%b required 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet_%0d: out_valid=%b required 0", i, out_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_data   = $urandom;
            in_shift  = SB'($urandom_range(0, W - 1));
            in_op     = 2'($urandom_range(0, 3));
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL random_drain: pending=%0d out_valid=%b required pending=0 valid=0", exp_q.size(), out_valid);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
